// File: rtl/spimem_cache_pkg.sv
// rtl/spimem_cache_pkg.sv - shared types and address-field width helpers for the SPI flash line cache
package spimem_cache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DATA_W = 32;

   function automatic int off_w(input int words);
      return $clog2(words);
   endfunction

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   // Byte address = {tag, index, word offset, 2'b00}
   function automatic int tag_w(input int addr_w, input int lines, input int words);
      return addr_w - 2 - $clog2(lines) - $clog2(words);
   endfunction

endpackage

// File: rtl/spimem_cache_ram.sv
// rtl/spimem_cache_ram.sv - tag/valid/data storage: combinational read by index, synchronous word write
module spimem_cache_ram
   import spimem_cache_pkg::*;
#(
   parameter  int LINES = 16,
   parameter  int WORDS = 4,
   parameter  int TAG_W = 16,
   localparam int IDX_W = idx_w(LINES),
   localparam int OFF_W = off_w(WORDS)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [OFF_W-1:0]  rd_off,
   output logic [TAG_W-1:0]  rd_tag,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_word,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [OFF_W-1:0]  wr_off,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              tag_we,
   input  logic [TAG_W-1:0]  tag_wdata,
   input  logic              tag_set_valid
);

   logic [DATA_W-1:0] data_q [LINES][WORDS];
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINES-1:0]  valid_q;

   assign rd_tag   = tag_q[rd_idx];
   assign rd_valid = valid_q[rd_idx];
   assign rd_word  = data_q[rd_idx][rd_off];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[wr_idx][wr_off] <= wr_data;
      end
      if (tag_we) begin
         tag_q[wr_idx] <= tag_wdata;
      end
   end

   // Only the valid bits are reset; flush wins over a same-cycle line install
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else if (tag_we) begin
         valid_q[wr_idx] <= tag_set_valid;
      end
   end

endmodule

// File: rtl/spimem_line_cache.sv
// rtl/spimem_line_cache.sv - direct-mapped read-only line cache in front of spimemio; SPIMEM_CACHE_STATS_EN adds hit/miss counters
module spimem_line_cache
   import spimem_cache_pkg::*;
#(
   parameter int LINES  = 16,
   parameter int WORDS  = 4,
   parameter int ADDR_W = 24
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_rdata,
   input  logic              flush,
   output logic              flash_valid,
   input  logic              flash_ready,
   output logic [ADDR_W-1:0] flash_addr,
   input  logic [31:0]       flash_rdata
`ifdef SPIMEM_CACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int OFF_W = off_w(WORDS);
   localparam int IDX_W = idx_w(LINES);
   localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS);
   localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(WORDS - 1);

   state_t            state_q, state_d;
   logic [OFF_W-1:0]  cnt_q, cnt_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              kill_q, kill_d;
   logic              mem_ready_q, mem_ready_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic              flash_valid_q, flash_valid_d;
   logic [ADDR_W-1:0] flash_addr_q, flash_addr_d;

   logic [OFF_W-1:0]  req_off;
   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  rd_idx;
   logic [OFF_W-1:0]  rd_off;
   logic [TAG_W-1:0]  rd_tag;
   logic              rd_valid;
   logic [31:0]       rd_word;
   logic              lookup, hit, beat;
   logic              wr_en, tag_we;
   logic              unused_addr_bits;

   assign req_off = mem_addr[OFF_W+1:2];
   assign req_idx = mem_addr[OFF_W+2 +: IDX_W];
   assign req_tag = mem_addr[ADDR_W-1 -: TAG_W];
   assign unused_addr_bits = ^mem_addr[1:0];

   // While busy the storage is addressed by the latched request, not the live bus
   assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;
   assign rd_off = (state_q == IDLE) ? req_off : off_q;

   assign lookup = (state_q == IDLE) && mem_valid && !mem_ready_q;
   assign hit    = lookup && rd_valid && (rd_tag == req_tag);
   assign beat   = (state_q == FILL) && flash_valid_q && flash_ready;

   spimem_cache_ram #(
      .LINES (LINES),
      .WORDS (WORDS),
      .TAG_W (TAG_W)
   ) u_ram (
      .clk           (clk),
      .resetn        (resetn),
      .flush         (flush),
      .rd_idx        (rd_idx),
      .rd_off        (rd_off),
      .rd_tag        (rd_tag),
      .rd_valid      (rd_valid),
      .rd_word       (rd_word),
      .wr_en         (wr_en),
      .wr_idx        (idx_q),
      .wr_off        (cnt_q),
      .wr_data       (flash_rdata),
      .tag_we        (tag_we),
      .tag_wdata     (tag_q),
      .tag_set_valid (!(kill_q || flush))
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      off_d         = off_q;
      idx_d         = idx_q;
      tag_d         = tag_q;
      kill_d        = kill_q;
      mem_ready_d   = 1'b0;
      mem_rdata_d   = mem_rdata_q;
      flash_valid_d = flash_valid_q;
      flash_addr_d  = flash_addr_q;
      wr_en         = 1'b0;
      tag_we        = 1'b0;

      case (state_q)
         IDLE: begin
            if (hit) begin
               mem_ready_d = 1'b1;
               mem_rdata_d = rd_word;
            end else if (lookup) begin
               state_d       = FILL;
               cnt_d         = '0;
               off_d         = req_off;
               idx_d         = req_idx;
               tag_d         = req_tag;
               flash_valid_d = 1'b1;
               flash_addr_d  = {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
            end
         end
         FILL: begin
            // A flush mid-fill must not let the line it raced with become valid
            if (flush) begin
               kill_d = 1'b1;
            end
            if (beat) begin
               wr_en        = 1'b1;
               cnt_d        = cnt_q + 1'b1;
               flash_addr_d = flash_addr_q + ADDR_W'(4);
               if (cnt_q == LAST_CNT) begin
                  tag_we        = 1'b1;
                  flash_valid_d = 1'b0;
                  state_d       = RESP;
               end
            end
         end
         RESP: begin
            if (mem_valid) begin
               mem_ready_d = 1'b1;
               mem_rdata_d = rd_word;
            end
            kill_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d       = IDLE;
            flash_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         off_q         <= '0;
         idx_q         <= '0;
         tag_q         <= '0;
         kill_q        <= 1'b0;
         mem_ready_q   <= 1'b0;
         mem_rdata_q   <= '0;
         flash_valid_q <= 1'b0;
         flash_addr_q  <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         off_q         <= off_d;
         idx_q         <= idx_d;
         tag_q         <= tag_d;
         kill_q        <= kill_d;
         mem_ready_q   <= mem_ready_d;
         mem_rdata_q   <= mem_rdata_d;
         flash_valid_q <= flash_valid_d;
         flash_addr_q  <= flash_addr_d;
      end
   end

   assign mem_ready   = mem_ready_q;
   assign mem_rdata   = mem_rdata_q;
   assign flash_valid = flash_valid_q;
   assign flash_addr  = flash_addr_q;

`ifdef SPIMEM_CACHE_STATS_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (flush) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit && (hit_count != 32'hFFFF_FFFF)) begin
            hit_count <= hit_count + 32'd1;
         end
         if (lookup && !hit && (miss_count != 32'hFFFF_FFFF)) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_spimem_line_cache.sv
// tb/tb_spimem_line_cache.sv - directed self-checking bench for spimem_line_cache
module tb_spimem_line_cache;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [23:0] mem_addr = '0;
   logic [31:0] mem_rdata;
   logic        flush = 1'b0;
   logic        flash_valid;
   logic        flash_ready = 1'b1;
   logic [23:0] flash_addr;
   logic [31:0] flash_rdata;
`ifdef SPIMEM_CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int total = 0;
   int bad   = 0;
   logic [23:0] fq[$];

   spimem_line_cache dut (
      .clk         (clk),
      .resetn      (resetn),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .flush       (flush),
      .flash_valid (flash_valid),
      .flash_ready (flash_ready),
      .flash_addr  (flash_addr),
      .flash_rdata (flash_rdata)
`ifdef SPIMEM_CACHE_STATS_EN
      ,
      .hit_count   (hit_count),
      .miss_count  (miss_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] fdata(input logic [23:0] a);
      return {a[23:8] ^ 16'hBEEF, a[7:0], 8'h3C};
   endfunction

   assign flash_rdata = fdata(flash_addr);

   // Beats are logged mid-cycle, after the bench has updated flash_ready
   always @(negedge clk) begin
      #2;
      if (flash_valid === 1'b1 && flash_ready === 1'b1) fq.push_back(flash_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_read(input logic [23:0] a, input int fl, input int st,
                          output logic [31:0] d, output int lat);
      @(negedge clk);
      fq.delete();
      mem_addr  = a;
      mem_valid = 1'b1;
      lat       = 0;
      d         = 'x;
      if (fl == 0) flush = 1'b1;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         flush       = (lat == fl);
         flash_ready = (lat != st);
         if (mem_ready === 1'b1) begin
            d = mem_rdata;
            break;
         end
      end
      flush       = 1'b0;
      flash_ready = 1'b1;
      mem_valid   = 1'b0;
   endtask

   task automatic rd_chk(input string t, input logic [23:0] a, input int fl, input int st,
                         input int exp_lat);
      logic [31:0] d;
      int          lat;
      logic [23:0] base;
      do_read(a, fl, st, d, lat);
      base = a & 24'hFFFFF0;
      chk({t, ".lat"}, 32'(lat), 32'(exp_lat));
      chk({t, ".data"}, d, fdata({a[23:2], 2'b00}));
      if (exp_lat == 1) begin
         chk({t, ".nbeats"}, 32'(fq.size()), 32'd0);
      end else begin
         chk({t, ".nbeats"}, 32'(fq.size()), 32'd4);
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.addr%0d", t, i),
                (i < fq.size()) ? {8'h00, fq[i]} : 32'hxxxx_xxxx,
                {8'h00, base + 24'(4 * i)});
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst.mem_ready", {31'd0, mem_ready}, 32'd0);
      chk("rst.mem_rdata", mem_rdata, 32'd0);
      chk("rst.flash_valid", {31'd0, flash_valid}, 32'd0);
      chk("rst.flash_addr", {8'h00, flash_addr}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      rd_chk("t1.cold", 24'h000104, -1, -1, 6);
      rd_chk("t2.hit", 24'h00010C, -1, -1, 1);
`ifdef SPIMEM_CACHE_STATS_EN
      chk("t6.hits", hit_count, 32'd1);
      chk("t6.misses", miss_count, 32'd1);
`endif
      rd_chk("t2.hit0", 24'h000100, -1, -1, 1);

      rd_chk("t3.alias_stall", 24'h000500, -1, 2, 7);
      rd_chk("t3.evicted", 24'h000100, -1, -1, 6);

      rd_chk("t4.prehit", 24'h000104, -1, -1, 1);
      rd_chk("t4.flush_same_cycle", 24'h000108, 0, -1, 1);
      rd_chk("t4.after_flush", 24'h000108, -1, -1, 6);
      rd_chk("t4.refilled", 24'h00010C, -1, -1, 1);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
`ifdef SPIMEM_CACHE_STATS_EN
      chk("t6.hits_flushed", hit_count, 32'd0);
      chk("t6.misses_flushed", miss_count, 32'd0);
`endif
      rd_chk("t4.flush_pulse", 24'h000100, -1, -1, 6);
      rd_chk("t4.flush_midfill", 24'h000500, 1, -1, 6);
      rd_chk("t4.killed_line", 24'h000504, -1, -1, 6);
      rd_chk("t4.kill_cleared", 24'h000508, -1, -1, 1);

      @(negedge clk);
      mem_addr  = 24'h000140;
      mem_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t5.pre_flash_valid", {31'd0, flash_valid}, 32'd1);
      #3;
      resetn = 1'b0;
      #1;
      chk("t5.async_flash_valid", {31'd0, flash_valid}, 32'd0);
      chk("t5.async_mem_ready", {31'd0, mem_ready}, 32'd0);
      chk("t5.async_flash_addr", {8'h00, flash_addr}, 32'd0);
      mem_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      rd_chk("t5.partial_line", 24'h000140, -1, -1, 6);
      rd_chk("t5.valid_cleared", 24'h000508, -1, -1, 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
